// File: rtl/regfile_sb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sb_pkg
// Shared sizing constants and types for the register file / write scoreboard
// slice. Imported by the interface, the scoreboard and the top.
//   DW       : data width of every register and of the writeback bus
//   AW       : register address width (NREG = 2**AW registers, R0 reads zero)
//   CNT_W    : width of each per-register in-flight write counter
//   CNT_MAX  : saturation value of a counter (2**CNT_W - 1)
//   REG_ZERO : address of the hardwired-zero register
// -----------------------------------------------------------------------------
package regfile_sb_pkg;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 2;
  localparam int NREG  = 1 << AW;

  typedef logic [DW-1:0]    data_t;
  typedef logic [AW-1:0]    addr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [NREG-1:0]  pending_t;

  localparam cnt_t  CNT_MAX  = '1;
  localparam addr_t REG_ZERO = '0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
// Bundles the writeback write port, the two decode read ports and the issue /
// scoreboard handshake of regfile_sb.
//   master : the pipeline side (writeback stage + decode); drives RW/DA/BUS_D,
//            the read addresses and the issue request, observes read data,
//            STALL, PENDING and SB_ERR.
//   slave  : the register file itself (regfile_sb).
// -----------------------------------------------------------------------------
interface regfile_sb_if;
  import regfile_sb_pkg::*;

  // Writeback write port
  logic     RW;
  addr_t    DA;
  data_t    BUS_D;

  // Decode read ports
  addr_t    AA;
  addr_t    BA;
  logic     USE_A;
  logic     USE_B;
  data_t    A_DATA;
  data_t    B_DATA;

  // Issue / scoreboard
  logic     ISSUE;
  logic     ISSUE_RW;
  addr_t    ISSUE_DA;
  logic     STALL;
  pending_t PENDING;
  logic     SB_ERR;

  modport master (
    output RW, DA, BUS_D,
    output AA, BA, USE_A, USE_B,
    output ISSUE, ISSUE_RW, ISSUE_DA,
    input  A_DATA, B_DATA, STALL, PENDING, SB_ERR
  );

  modport slave (
    input  RW, DA, BUS_D,
    input  AA, BA, USE_A, USE_B,
    input  ISSUE, ISSUE_RW, ISSUE_DA,
    output A_DATA, B_DATA, STALL, PENDING, SB_ERR
  );

endinterface : regfile_sb_if

// File: rtl/regfile_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Per-register in-flight write counters. Decode issuing an instruction that
// writes Rn bumps counter n; the matching writeback decrements it. A read of a
// register with outstanding writes is a hazard and stalls issue, unless the
// only outstanding write is landing this very cycle (the read bypass covers
// it). A destination whose counter is saturated also stalls issue.
//   clk, rst  : clock, asynchronous active-high reset
//   wb, da    : accepted writeback this cycle and its destination
//   aa, ba    : read port addresses; use_a/use_b qualify them
//   issue     : decode issue request; issue_rw/issue_da describe its write
//   stall     : issue refused this cycle (combinational)
//   pending   : bit n set while counter n is non-zero (bit 0 always 0)
//   sb_err    : sticky, writeback arrived for a register with no pending write
// -----------------------------------------------------------------------------
module reg_scoreboard
  import regfile_sb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wb,
  input  addr_t    da,
  input  addr_t    aa,
  input  addr_t    ba,
  input  logic     use_a,
  input  logic     use_b,
  input  logic     issue,
  input  logic     issue_rw,
  input  addr_t    issue_da,
  output logic     stall,
  output pending_t pending,
  output logic     sb_err
);

  cnt_t     cnt [NREG];
  logic     haz_a;
  logic     haz_b;
  logic     full;
  logic     acc;
  pending_t inc_v;
  pending_t dec_v;

  // A hazard is waived only when the single outstanding write is the one
  // arriving now: the bypass mux in the top then delivers the fresh value.
  function automatic logic read_hazard(input logic use_p, input addr_t a,
                                       input cnt_t c, input logic wb_i,
                                       input addr_t da_i);
    return use_p && (a != REG_ZERO) && (c != '0) &&
           !((c == cnt_t'(1)) && wb_i && (da_i == a));
  endfunction

  assign haz_a = read_hazard(use_a, aa, cnt[aa], wb, da);
  assign haz_b = read_hazard(use_b, ba, cnt[ba], wb, da);

  // A saturated counter may still accept a new issue when a writeback to the
  // same register frees a slot in the same cycle (inc and dec cancel).
  assign full = issue_rw && (issue_da != REG_ZERO) &&
                (cnt[issue_da] == CNT_MAX) && !(wb && (da == issue_da));

  assign stall = issue && (haz_a || haz_b || full);
  assign acc   = issue && !stall && issue_rw && (issue_da != REG_ZERO);

  // NOTE: every always_comb output gets a default before any conditional
  // update so that no path leaves it unassigned and infers a latch.
  always_comb begin
    inc_v   = '0;
    dec_v   = '0;
    pending = '0;
    for (int n = 1; n < NREG; n++) begin
      inc_v[n]   = acc && (issue_da == addr_t'(n));
      dec_v[n]   = wb  && (da == addr_t'(n));
      pending[n] = (cnt[n] != '0);
    end
  end

  // NOTE: the counter array is small and must read as empty straight after
  // reset, so it is reset element by element rather than left as memory.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NREG; n++) begin
        cnt[n] <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      for (int n = 1; n < NREG; n++) begin
        // A writeback with nothing outstanding is a pipeline bookkeeping bug;
        // flag it and hold the counter at zero rather than wrapping.
        if (dec_v[n] && (cnt[n] == '0)) begin
          sb_err <= 1'b1;
        end
        unique case ({inc_v[n], dec_v[n]})
          2'b10:   cnt[n] <= cnt[n] + cnt_t'(1);
          2'b01:   if (cnt[n] != '0) cnt[n] <= cnt[n] - cnt_t'(1);
          default: cnt[n] <= cnt[n];
        endcase
      end
    end
  end

endmodule : reg_scoreboard

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Register file with write scoreboard at the receiving end of writeback.
// One write port (RW/DA/BUS_D) and two combinational read ports with
// same-cycle writeback bypass; R0 is hardwired to zero. The scoreboard
// sub-module tracks in-flight writes per register and stalls decode on
// read-after-write hazards or counter saturation.
//   CLOCK : single clock, all state updates on the rising edge
//   RESET : asynchronous active-high, clears registers, counters and SB_ERR
//   bus   : regfile_sb_if.slave - write port, read ports, issue handshake,
//           A_DATA/B_DATA, STALL, PENDING, SB_ERR
// -----------------------------------------------------------------------------
module regfile_sb
  import regfile_sb_pkg::*;
(
  input  logic         CLOCK,
  input  logic         RESET,
  regfile_sb_if.slave  bus
);

  data_t regs [NREG];
  logic  wb;
  data_t a_data;
  data_t b_data;

  // Writes to R0 are dropped here and never reach the scoreboard either.
  assign wb = bus.RW && (bus.DA != REG_ZERO);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int n = 0; n < NREG; n++) begin
        regs[n] <= '0;
      end
    end else if (wb) begin
      regs[bus.DA] <= bus.BUS_D;
    end
  end

  // Read ports: R0 forces zero, otherwise a writeback landing this cycle to
  // the same address wins over the stored value.
  always_comb begin
    a_data = '0;
    if (bus.AA != REG_ZERO) begin
      a_data = (wb && (bus.DA == bus.AA)) ? bus.BUS_D : regs[bus.AA];
    end
  end

  always_comb begin
    b_data = '0;
    if (bus.BA != REG_ZERO) begin
      b_data = (wb && (bus.DA == bus.BA)) ? bus.BUS_D : regs[bus.BA];
    end
  end

  assign bus.A_DATA = a_data;
  assign bus.B_DATA = b_data;

  reg_scoreboard u_scoreboard (
    .clk      (CLOCK),
    .rst      (RESET),
    .wb       (wb),
    .da       (bus.DA),
    .aa       (bus.AA),
    .ba       (bus.BA),
    .use_a    (bus.USE_A),
    .use_b    (bus.USE_B),
    .issue    (bus.ISSUE),
    .issue_rw (bus.ISSUE_RW),
    .issue_da (bus.ISSUE_DA),
    .stall    (bus.STALL),
    .pending  (bus.PENDING),
    .sb_err   (bus.SB_ERR)
  );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Directed self-checking bench for regfile_sb. Each step drives the pipeline
// inputs, pushes the values the step should produce onto a scoreboard queue,
// and check() pops and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  typedef enum int {K_A, K_B, K_STALL, K_PEND, K_ERR} kind_e;

  typedef struct {
    kind_e       kind;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   vectors;
  int   miscompares;

  regfile_sb_if bus ();

  regfile_sb dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_A:     return bus.A_DATA;
      K_B:     return bus.B_DATA;
      K_STALL: return {31'd0, bus.STALL};
      K_PEND:  return bus.PENDING;
      default: return {31'd0, bus.SB_ERR};
    endcase
  endfunction

  task automatic push(input kind_e k, input string tag, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.tag  = tag;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.kind);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    bus.RW       = 1'b0;
    bus.DA       = '0;
    bus.BUS_D    = '0;
    bus.AA       = '0;
    bus.BA       = '0;
    bus.USE_A    = 1'b0;
    bus.USE_B    = 1'b0;
    bus.ISSUE    = 1'b0;
    bus.ISSUE_RW = 1'b0;
    bus.ISSUE_DA = '0;
  endtask

  task automatic issue_wr(input addr_t d);
    bus.ISSUE    = 1'b1;
    bus.ISSUE_RW = 1'b1;
    bus.ISSUE_DA = d;
  endtask

  task automatic writeback(input addr_t d, input data_t v);
    bus.RW    = 1'b1;
    bus.DA    = d;
    bus.BUS_D = v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle();

    // Reset state
    #2;
    bus.AA = 5'd5;
    bus.BA = 5'd0;
    push(K_A, "rst_a", 32'h0);
    push(K_B, "rst_b", 32'h0);
    push(K_PEND, "rst_pending", 32'h0);
    push(K_STALL, "rst_stall", 32'h0);
    push(K_ERR, "rst_sb_err", 32'h0);
    check();
    @(negedge clk);
    rst = 1'b0;

    // Write to R0 is discarded, no bypass either
    idle();
    writeback(5'd0, 32'hFFFF_FFFF);
    push(K_A, "r0_write_cycle", 32'h0);
    check();
    next_cycle();
    idle();
    push(K_A, "r0_after_write", 32'h0);
    push(K_ERR, "r0_no_sb_err", 32'h0);
    check();

    // R7: issue, then writeback with same-cycle bypass
    idle();
    issue_wr(5'd7);
    push(K_STALL, "r7_issue_stall", 32'h0);
    check();
    next_cycle();
    idle();
    push(K_PEND, "r7_pending", 32'h0000_0080);
    check();
    writeback(5'd7, 32'hDEAD_BEEF);
    bus.AA = 5'd7;
    bus.BA = 5'd5;
    push(K_A, "r7_bypass", 32'hDEAD_BEEF);
    push(K_B, "r7_other_port", 32'h0);
    check();
    next_cycle();
    idle();
    bus.AA = 5'd7;
    push(K_A, "r7_stored", 32'hDEAD_BEEF);
    push(K_PEND, "r7_pending_clear", 32'h0);
    push(K_ERR, "r7_no_sb_err", 32'h0);
    check();

    // R3: read-after-write hazard, released by the arriving writeback
    idle();
    issue_wr(5'd3);
    push(K_STALL, "r3_issue_stall", 32'h0);
    check();
    next_cycle();
    idle();
    bus.ISSUE = 1'b1;
    bus.USE_B = 1'b1;
    bus.BA    = 5'd3;
    push(K_STALL, "r3_haz_b", 32'h1);
    check();
    bus.USE_B = 1'b0;
    push(K_STALL, "r3_use_b_gated", 32'h0);
    check();
    idle();
    bus.ISSUE = 1'b1;
    bus.USE_A = 1'b1;
    bus.AA    = 5'd3;
    push(K_STALL, "r3_haz_a", 32'h1);
    push(K_PEND, "r3_pending", 32'h0000_0008);
    check();
    next_cycle();
    push(K_STALL, "r3_haz_a_held", 32'h1);
    check();
    writeback(5'd3, 32'h0000_0012);
    push(K_STALL, "r3_wb_releases", 32'h0);
    push(K_A, "r3_bypass", 32'h0000_0012);
    check();
    next_cycle();
    idle();
    bus.AA = 5'd3;
    push(K_PEND, "r3_pending_clear", 32'h0);
    push(K_A, "r3_stored", 32'h0000_0012);
    check();

    // R4: fill the counter to CNT_MAX
    for (int i = 0; i < 3; i++) begin
      idle();
      issue_wr(5'd4);
      push(K_STALL, $sformatf("r4_issue%0d", i), 32'h0);
      check();
      next_cycle();
    end
    idle();
    issue_wr(5'd4);
    push(K_PEND, "r4_pending", 32'h0000_0010);
    push(K_STALL, "r4_full", 32'h1);
    check();
    writeback(5'd4, 32'h0000_0044);
    push(K_STALL, "r4_full_with_wb", 32'h0);
    check();
    next_cycle();
    idle();
    issue_wr(5'd4);
    push(K_STALL, "r4_still_full", 32'h1);
    check();
    // cnt == 3: writeback does not waive the read hazard, but still drains one
    idle();
    bus.ISSUE = 1'b1;
    bus.USE_A = 1'b1;
    bus.AA    = 5'd4;
    writeback(5'd4, 32'h0000_0045);
    push(K_STALL, "r4_haz_multi", 32'h1);
    push(K_A, "r4_bypass", 32'h0000_0045);
    check();
    next_cycle();

    // R9: simultaneous issue and writeback at cnt == 1
    idle();
    issue_wr(5'd9);
    push(K_STALL, "r9_issue_stall", 32'h0);
    check();
    next_cycle();
    idle();
    issue_wr(5'd9);
    writeback(5'd9, 32'h0000_0099);
    push(K_STALL, "r9_issue_and_wb", 32'h0);
    check();
    next_cycle();
    idle();
    push(K_PEND, "r9_cnt_held", 32'h0000_0210);
    check();
    // cnt == 1 and the writeback lands now: bypass waives the hazard
    bus.ISSUE = 1'b1;
    bus.USE_A = 1'b1;
    bus.AA    = 5'd9;
    writeback(5'd9, 32'h0000_009A);
    push(K_STALL, "r9_bypass_no_haz", 32'h0);
    push(K_A, "r9_bypass", 32'h0000_009A);
    check();
    next_cycle();
    idle();
    push(K_PEND, "r9_pending_clear", 32'h0000_0010);
    check();

    // Underflow sets sticky SB_ERR
    idle();
    writeback(5'd12, 32'h0000_000C);
    push(K_ERR, "r12_err_not_yet", 32'h0);
    check();
    next_cycle();
    idle();
    push(K_ERR, "r12_err_set", 32'h1);
    push(K_PEND, "r12_no_pending", 32'h0000_0010);
    check();
    next_cycle();
    next_cycle();
    push(K_ERR, "r12_err_sticky", 32'h1);
    check();

    // Asynchronous reset mid-cycle with cnt[4] == 2
    idle();
    bus.AA = 5'd7;
    bus.BA = 5'd4;
    push(K_A, "pre_rst_r7", 32'hDEAD_BEEF);
    push(K_B, "pre_rst_r4", 32'h0000_0045);
    push(K_PEND, "pre_rst_pending", 32'h0000_0010);
    check();
    rst = 1'b1;
    push(K_A, "async_rst_r7", 32'h0);
    push(K_B, "async_rst_r4", 32'h0);
    push(K_PEND, "async_rst_pending", 32'h0);
    push(K_ERR, "async_rst_sb_err", 32'h0);
    check();
    @(negedge clk);
    rst = 1'b0;

    // Scoreboard usable again after reset
    idle();
    issue_wr(5'd5);
    push(K_STALL, "post_rst_issue", 32'h0);
    check();
    next_cycle();
    idle();
    push(K_PEND, "post_rst_pending", 32'h0000_0020);
    check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
# regfile_sb

Register file plus write scoreboard that sits at the receiving end of the writeback stage. It consumes the writeback write port (RW, DA, BUS_D) and serves two combinational read ports to decode. A per-register in-flight counter lets decode detect read-after-write hazards and stall issue until the pending writeback lands.

## Interface
- DW, 32, data width of every register and of BUS_D
- AW, 5, register address width (2^AW registers, R0 hardwired zero)
- CNT_W, 2, width of each per-register in-flight write counter (max CNT_MAX = 2^CNT_W-1 = 3)

- CLOCK  in  1  single clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high; clears all state immediately
- RW  in  1  writeback write enable
- DA  in  AW  writeback destination register
- BUS_D  in  DW  writeback data
- AA  in  AW  read port A address
- BA  in  AW  read port B address
- USE_A  in  1  decoded instruction reads port A
- USE_B  in  1  decoded instruction reads port B
- ISSUE  in  1  decode requests to issue the current instruction
- ISSUE_RW  in  1  issuing instruction will write a register
- ISSUE_DA  in  AW  destination register of issuing instruction
- A_DATA  out  DW  read port A data
- B_DATA  out  DW  read port B data
- STALL  out  1  issue refused this cycle
- PENDING  out  2^AW  bit n set when counter n is non-zero
- SB_ERR  out  1  sticky: writeback arrived for a register with no pending write

## Operation
- Reset values: all registers 0, all counters 0, SB_ERR 0; hence A_DATA/B_DATA 0 for any address, PENDING 0, STALL 0.
- Write: on rising CLOCK, if RW and DA != 0, reg[DA] <= BUS_D. Writes to R0 are discarded.
- Read: A_DATA = 0 if AA == 0; else BUS_D if RW and DA == AA (same-cycle bypass); else reg[AA]. B identical with BA.
- Write accepted: wb = RW & (DA != 0).
- Hazard on A: USE_A & AA != 0 & cnt[AA] != 0, except no hazard when cnt[AA] == 1 and wb and DA == AA (bypass covers it). Same rule for B.
- Full: ISSUE_RW & ISSUE_DA != 0 & cnt[ISSUE_DA] == CNT_MAX & !(wb & DA == ISSUE_DA).
- STALL = ISSUE & (hazA | hazB | full). Combinational, no registered state.
- Accept: acc = ISSUE & ~STALL & ISSUE_RW & ISSUE_DA != 0.
- Counter update per register n, on rising CLOCK: inc = acc & ISSUE_DA == n; dec = wb & DA == n. inc only: +1. dec only: -1. Both: unchanged. Neither: unchanged.
- Underflow: dec with cnt == 0 leaves counter at 0 and sets SB_ERR; SB_ERR clears only on RESET.
- Counter never exceeds CNT_MAX; full forces STALL, so inc never occurs at CNT_MAX without a matching dec.
- R0 counter does not exist; PENDING[0] is always 0.

## Timing
- Read latency 0: combinational from AA/BA/RW/DA/BUS_D.
- Write latency: data on BUS_D at cycle N is in reg[] from cycle N+1; visible at cycle N via bypass.
- Scoreboard: accepted issue at cycle N makes PENDING[ISSUE_DA] = 1 from N+1; writeback at cycle M clears it from M+1 if count was 1.
- Stall is evaluated every cycle; decode holds ISSUE and its fields stable while STALL is high.
- RESET asserted mid-operation: registers, counters and SB_ERR cleared asynchronously; in-flight writebacks are lost (whole pipeline resets together). Deassertion is synchronous to CLOCK via the system reset synchronizer.

## Structure
- Shared package: DW, AW, CNT_W, CNT_MAX, REG_ZERO (address 0).
- Sub-module reg_scoreboard: counter array, hazard/full/STALL logic, PENDING, SB_ERR. Top regfile_sb holds register array, bypass muxes and instantiates reg_scoreboard.

## Test plan
- Reset then read AA=5, BA=0 -> A_DATA=0, B_DATA=0, PENDING=0, STALL=0; write RW=1 DA=0 BUS_D=0xFFFFFFFF -> R0 still reads 0.
- Write RW=1 DA=7 BUS_D=0xDEADBEEF with AA=7 same cycle -> A_DATA=0xDEADBEEF that cycle (bypass) and next cycle with RW=0.
- Issue ISSUE_RW=1 ISSUE_DA=3; next cycle ISSUE with USE_A=1 AA=3 -> STALL=1; writeback DA=3 BUS_D=0x12 arrives -> STALL=0 same cycle, A_DATA=0x12, PENDING[3] cleared next cycle.
- Three accepted issues to R4 -> cnt=3; fourth issue to R4 -> STALL=1; same cycle as writeback to R4 -> STALL=0, cnt stays 3.
- Simultaneous accepted issue to R9 and writeback to R9 with cnt=1 -> cnt remains 1, PENDING[9]=1.
- Writeback RW=1 DA=12 with PENDING[12]=0 -> SB_ERR=1 next cycle, stays 1 until RESET; RESET pulse mid-stream with cnt[4]=2 -> all counters 0, SB_ERR 0 immediately.
